// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared header sizes, protocol constants and parser state type
package udp_pkg;

    localparam int ETH_HDR_LEN = 14;
    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;

    localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam logic [7:0]  IP_VER_IHL5  = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        ETH,
        IP,
        UDP,
        PAYLOAD,
        DROP
    } udp_rx_state_e;

endpackage

// File: rtl/udp_rx_parser_if.sv
// rtl/udp_rx_parser_if.sv - MAC byte stream in, UDP payload stream and status out
interface udp_rx_parser_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_sof;
    logic        o_eof;
    logic [15:0] o_len;
    logic        drop;
    logic        error;

    modport master (
        output rx_valid, rx_data, rx_last,
        input  o_valid, o_data, o_sof, o_eof, o_len, drop, error
    );

    modport slave (
        input  rx_valid, rx_data, rx_last,
        output o_valid, o_data, o_sof, o_eof, o_len, drop, error
    );

endinterface

// File: rtl/ip_csum_acc.sv
// rtl/ip_csum_acc.sv - ones-complement accumulator over byte pairs with end-around carry
module ip_csum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] sum,
    output logic        ok
);

    logic [15:0] acc;
    logic [7:0]  hi;
    logic        phase;
    logic [16:0] raw;
    logic [15:0] folded;

    // folded already includes the word completed by the current low byte
    assign raw    = {1'b0, acc} + {1'b0, hi, data};
    assign folded = raw[15:0] + {15'd0, raw[16]};
    assign sum    = phase ? folded : acc;
    assign ok     = en && phase && (folded == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= 16'd0;
            hi    <= 8'd0;
            phase <= 1'b0;
        end else if (en) begin
            if (!phase) begin
                hi <= data;
            end else begin
                acc <= folded;
            end
            phase <= ~phase;
        end
    end

endmodule

// File: rtl/udp_rx_parser.sv
// rtl/udp_rx_parser.sv - Ethernet/IPv4/UDP header parser and port filter emitting the UDP payload
// Optional: define UDP_RX_IPCSUM_EN to verify the IPv4 header checksum.
module udp_rx_parser
    import udp_pkg::*;
#(
    parameter logic [15:0] DEST_PORT   = 16'd8080,
    parameter bit          PORT_FILTER = 1'b1,
    parameter int          MAX_PAYLOAD = 1472
) (
    input logic            clk,
    input logic            rst,
    udp_rx_parser_if.slave bus
);

    localparam logic [4:0]  ETH_LAST = 5'(ETH_HDR_LEN - 1);
    localparam logic [4:0]  IP_LAST  = 5'(IP_HDR_LEN - 1);
    localparam logic [4:0]  UDP_LAST = 5'(UDP_HDR_LEN - 1);
    localparam logic [15:0] MAX_PL   = 16'(MAX_PAYLOAD);

    udp_rx_state_e state, state_n;
    logic [4:0]  idx, idx_n;
    logic [7:0]  etype_hi, etype_hi_n;
    logic        ip_bad, ip_bad_n;
    logic [15:0] dport, dport_n;
    logic [15:0] ulen, ulen_n;
    logic [15:0] rem, rem_n;
    logic        first, first_n;
    logic [15:0] pl_len;

    logic        valid_r, valid_n;
    logic [7:0]  data_r, data_n;
    logic        sof_r, sof_n;
    logic        eof_r, eof_n;
    logic [15:0] len_r, len_n;
    logic        drop_r, drop_n;
    logic        error_r, error_n;

    logic        csum_ok;

`ifdef UDP_RX_IPCSUM_EN
    logic [15:0] csum_sum;

    ip_csum_acc u_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != IP),
        .en   (bus.rx_valid && (state == IP)),
        .data (bus.rx_data),
        .sum  (csum_sum),
        .ok   (csum_ok)
    );
`else
    assign csum_ok = 1'b1;
`endif

    assign pl_len = ulen - 16'd8;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 5'd0;
            etype_hi <= 8'd0;
            ip_bad   <= 1'b0;
            dport    <= 16'd0;
            ulen     <= 16'd0;
            rem      <= 16'd0;
            first    <= 1'b0;
            valid_r  <= 1'b0;
            data_r   <= 8'd0;
            sof_r    <= 1'b0;
            eof_r    <= 1'b0;
            len_r    <= 16'd0;
            drop_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            etype_hi <= etype_hi_n;
            ip_bad   <= ip_bad_n;
            dport    <= dport_n;
            ulen     <= ulen_n;
            rem      <= rem_n;
            first    <= first_n;
            valid_r  <= valid_n;
            data_r   <= data_n;
            sof_r    <= sof_n;
            eof_r    <= eof_n;
            len_r    <= len_n;
            drop_r   <= drop_n;
            error_r  <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        etype_hi_n = etype_hi;
        ip_bad_n   = ip_bad;
        dport_n    = dport;
        ulen_n     = ulen;
        rem_n      = rem;
        first_n    = first;
        valid_n    = 1'b0;
        data_n     = data_r;
        sof_n      = 1'b0;
        eof_n      = 1'b0;
        len_n      = len_r;
        drop_n     = 1'b0;
        error_n    = error_r;

        if (bus.rx_valid) begin
            case (state)
                IDLE: begin
                    idx_n    = 5'd1;
                    ip_bad_n = 1'b0;
                    if (bus.rx_last) begin
                        error_n = 1'b1;
                    end else begin
                        state_n = ETH;
                    end
                end
                ETH: begin
                    if (idx == ETH_LAST - 5'd1) begin
                        etype_hi_n = bus.rx_data;
                    end
                    if (bus.rx_last) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else if (idx == ETH_LAST) begin
                        idx_n = 5'd0;
                        if ({etype_hi, bus.rx_data} != ETYPE_IPV4) begin
                            drop_n  = 1'b1;
                            state_n = DROP;
                        end else begin
                            state_n = IP;
                        end
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
                IP: begin
                    if ((idx == 5'd0 && bus.rx_data != IP_VER_IHL5) ||
                        (idx == 5'd9 && bus.rx_data != IP_PROTO_UDP)) begin
                        ip_bad_n = 1'b1;
                    end
                    if (bus.rx_last) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else if (idx == IP_LAST) begin
                        idx_n = 5'd0;
                        if (ip_bad_n || !csum_ok) begin
                            drop_n  = 1'b1;
                            state_n = DROP;
                        end else begin
                            state_n = UDP;
                        end
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
                UDP: begin
                    case (idx)
                        5'd2:    dport_n[15:8] = bus.rx_data;
                        5'd3:    dport_n[7:0]  = bus.rx_data;
                        5'd4:    ulen_n[15:8]  = bus.rx_data;
                        5'd5:    ulen_n[7:0]   = bus.rx_data;
                        default: ;
                    endcase
                    if (bus.rx_last) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else if (idx == UDP_LAST) begin
                        idx_n = 5'd0;
                        if (ulen < 16'd9 || pl_len > MAX_PL ||
                            (PORT_FILTER && dport != DEST_PORT)) begin
                            drop_n  = 1'b1;
                            state_n = DROP;
                        end else begin
                            rem_n   = pl_len;
                            first_n = 1'b1;
                            state_n = PAYLOAD;
                        end
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
                PAYLOAD: begin
                    valid_n = 1'b1;
                    data_n  = bus.rx_data;
                    sof_n   = first;
                    first_n = 1'b0;
                    rem_n   = rem - 16'd1;
                    // rem still holds the full payload length on the first byte
                    if (first) begin
                        len_n = rem;
                    end
                    if (rem == 16'd1) begin
                        eof_n   = 1'b1;
                        state_n = bus.rx_last ? IDLE : DROP;
                    end else if (bus.rx_last) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end
                end
                DROP: begin
                    if (bus.rx_last) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.o_valid = valid_r;
    assign bus.o_data  = data_r;
    assign bus.o_sof   = sof_r;
    assign bus.o_eof   = eof_r;
    assign bus.o_len   = len_r;
    assign bus.drop    = drop_r;
    assign bus.error   = error_r;

endmodule

// File: tb/tb_udp_rx_parser.sv
// tb/tb_udp_rx_parser.sv - scoreboard bench for udp_rx_parser with directed frames
module tb_udp_rx_parser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    udp_rx_parser_if bus ();

    udp_rx_parser #(
        .DEST_PORT   (16'd8080),
        .PORT_FILTER (1'b1),
        .MAX_PAYLOAD (1472)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_drop;
        logic [7:0]  data;
        bit          sof;
        bit          eof;
        logic [15:0] len;
        int          cyc;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    logic [7:0] frame_q[$];
    logic [7:0] pl_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.o_valid === 1'b1 || bus.drop === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {30'd0, bus.o_valid, bus.drop}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_is_drop", {31'd0, bus.drop}, {31'd0, e.is_drop});
                chk("event_cycle", cyc, e.cyc);
                if (!e.is_drop) begin
                    chk("o_data", {24'd0, bus.o_data}, {24'd0, e.data});
                    chk("o_sof", {31'd0, bus.o_sof}, {31'd0, e.sof});
                    chk("o_eof", {31'd0, bus.o_eof}, {31'd0, e.eof});
                    chk("o_len", {16'd0, bus.o_len}, {16'd0, e.len});
                end
            end
        end else if (bus.o_sof === 1'b1 || bus.o_eof === 1'b1) begin
            chk("stray_marker", {30'd0, bus.o_sof, bus.o_eof}, 32'd0);
        end
    end

    task automatic build(input logic [15:0] etype, input logic [7:0] ip0, input logic [7:0] proto,
                         input logic [15:0] dport, input logic [15:0] ulen, input int npad,
                         input bit flip);
        logic [31:0] s;
        logic [15:0] c;
        logic [15:0] tot;
        frame_q.delete();
        for (int i = 0; i < 6; i++) frame_q.push_back((i == 0) ? 8'h02 : ((i == 5) ? 8'h01 : 8'h00));
        for (int i = 0; i < 6; i++) frame_q.push_back((i == 0) ? 8'h02 : ((i == 5) ? 8'h02 : 8'h00));
        frame_q.push_back(etype[15:8]);
        frame_q.push_back(etype[7:0]);
        tot = 16'd20 + ulen;
        frame_q.push_back(ip0);        frame_q.push_back(8'h00);
        frame_q.push_back(tot[15:8]);  frame_q.push_back(tot[7:0]);
        frame_q.push_back(8'h12);      frame_q.push_back(8'h34);
        frame_q.push_back(8'h40);      frame_q.push_back(8'h00);
        frame_q.push_back(8'h40);      frame_q.push_back(proto);
        frame_q.push_back(8'h00);      frame_q.push_back(8'h00);
        frame_q.push_back(8'h0a);      frame_q.push_back(8'h00);
        frame_q.push_back(8'h00);      frame_q.push_back(8'h01);
        frame_q.push_back(8'h0a);      frame_q.push_back(8'h00);
        frame_q.push_back(8'h00);      frame_q.push_back(8'h02);
        s = 32'd0;
        for (int w = 0; w < 10; w++) s += {16'd0, frame_q[14 + 2 * w], frame_q[15 + 2 * w]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        c = ~s[15:0] ^ {15'd0, flip};
        frame_q[24] = c[15:8];
        frame_q[25] = c[7:0];
        frame_q.push_back(8'h04);      frame_q.push_back(8'hD2);
        frame_q.push_back(dport[15:8]); frame_q.push_back(dport[7:0]);
        frame_q.push_back(ulen[15:8]); frame_q.push_back(ulen[7:0]);
        frame_q.push_back(8'h00);      frame_q.push_back(8'h00);
        foreach (pl_q[i]) frame_q.push_back(pl_q[i]);
        for (int i = 0; i < npad; i++) frame_q.push_back(8'h00);
    endtask

    // Called #1 after a rising edge; each byte is sampled on the following edge.
    task automatic send(input int n_send, input int last_at, input int gap, input int drop_at,
                        input int n_fwd, input bit eof_exp, input logic [15:0] len_exp);
        exp_t e;
        for (int i = 0; i < n_send; i++) begin
            for (int g = 0; g < (i % (gap + 1)); g++) begin
                bus.rx_valid = 1'b0;
                bus.rx_last  = 1'b1;
                bus.rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            bus.rx_valid = 1'b1;
            bus.rx_data  = frame_q[i];
            bus.rx_last  = (i == last_at);
            if (i == drop_at) begin
                e = '{is_drop: 1'b1, data: 8'd0, sof: 1'b0, eof: 1'b0, len: 16'd0, cyc: cyc + 1};
                exp_q.push_back(e);
            end
            if (i >= 42 && i < 42 + n_fwd) begin
                e = '{is_drop: 1'b0, data: frame_q[i], sof: (i == 42), eof: (eof_exp && i == 41 + n_fwd),
                      len: len_exp, cyc: cyc + 1};
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            bus.rx_valid = 1'b0;
            bus.rx_last  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_o_valid"}, {31'd0, bus.o_valid}, 32'd0);
        chk({tag, "_o_sof"},   {31'd0, bus.o_sof},   32'd0);
        chk({tag, "_o_eof"},   {31'd0, bus.o_eof},   32'd0);
        chk({tag, "_o_len"},   {16'd0, bus.o_len},   32'd0);
        chk({tag, "_drop"},    {31'd0, bus.drop},    32'd0);
        chk({tag, "_error"},   {31'd0, bus.error},   32'd0);
    endtask

    task automatic good_frame4();
        pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build(16'h0800, 8'h45, 8'd17, 16'd8080, 16'd12, 0, 1'b0);
    endtask

    initial begin
        int waited;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.rx_last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        good_frame4();
        send(frame_q.size(), frame_q.size() - 1, 0, -1, 4, 1'b1, 16'd4);
        chk("t1_error", {31'd0, bus.error}, 32'd0);

        pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build(16'h0800, 8'h45, 8'd17, 16'd8081, 16'd12, 0, 1'b0);
        send(frame_q.size(), frame_q.size() - 1, 0, 41, 0, 1'b0, 16'd0);
        good_frame4();
        send(frame_q.size(), frame_q.size() - 1, 0, -1, 4, 1'b1, 16'd4);

        pl_q = '{8'h5A};
        build(16'h0800, 8'h45, 8'd17, 16'd8080, 16'd9, 17, 1'b0);
        chk("t3_frame_size", frame_q.size(), 32'd60);
        send(frame_q.size(), frame_q.size() - 1, 0, -1, 1, 1'b1, 16'd1);
        chk("t3_error", {31'd0, bus.error}, 32'd0);

        good_frame4();
        send(44, 43, 0, -1, 2, 1'b0, 16'd4);
        chk("t4_error_set", {31'd0, bus.error}, 32'd1);
        for (int g = 0; g < 4; g++) begin
            good_frame4();
            send(frame_q.size(), frame_q.size() - 1, g, -1, 4, 1'b1, 16'd4);
            chk("t4_error_sticky", {31'd0, bus.error}, 32'd1);
        end

        good_frame4();
        build(16'h86DD, 8'h45, 8'd17, 16'd8080, 16'd12, 0, 1'b0);
        send(frame_q.size(), frame_q.size() - 1, 0, 13, 0, 1'b0, 16'd0);
        build(16'h0800, 8'h46, 8'd17, 16'd8080, 16'd12, 0, 1'b0);
        send(frame_q.size(), frame_q.size() - 1, 0, 33, 0, 1'b0, 16'd0);
        build(16'h0800, 8'h45, 8'd6, 16'd8080, 16'd12, 0, 1'b0);
        send(frame_q.size(), frame_q.size() - 1, 0, 33, 0, 1'b0, 16'd0);
        build(16'h0800, 8'h45, 8'd17, 16'd8080, 16'd8, 0, 1'b0);
        send(frame_q.size(), frame_q.size() - 1, 0, 41, 0, 1'b0, 16'd0);
        build(16'h0800, 8'h45, 8'd17, 16'd8080, 16'd1481, 0, 1'b0);
        send(frame_q.size(), frame_q.size() - 1, 0, 41, 0, 1'b0, 16'd0);

        pl_q.delete();
        for (int i = 0; i < 1472; i++) pl_q.push_back(8'(i * 7 + 3));
        build(16'h0800, 8'h45, 8'd17, 16'd8080, 16'd1480, 0, 1'b0);
        send(frame_q.size(), frame_q.size() - 1, 0, -1, 1472, 1'b1, 16'd1472);

`ifdef UDP_RX_IPCSUM_EN
        pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build(16'h0800, 8'h45, 8'd17, 16'd8080, 16'd12, 0, 1'b1);
        send(frame_q.size(), frame_q.size() - 1, 0, 33, 0, 1'b0, 16'd0);
`endif

        good_frame4();
        send(44, -1, 0, -1, 2, 1'b0, 16'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("midrst");
        good_frame4();
        send(frame_q.size(), frame_q.size() - 1, 1, -1, 4, 1'b1, 16'd4);
        chk("post_rst_error", {31'd0, bus.error}, 32'd0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
